// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: controller state encoding, RV32 major opcodes
// and the canonical NOP used when squashing a stage.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } ctrl_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic src_hit(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: decode/EX/MEM status in, stage controls out.
interface hazard_ctrl_if #(
    parameter logic [8:0] XLEN = 9'd64
);
    logic            id_valid;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [4:0]      ex_rd;
    logic            ex_mem_read;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dmem_req;
    logic            dmem_ack;

    logic            pc_stall;
    logic            decode_stall;
    logic            decode_flush;
    logic            ex_stall;
    logic            ex_bubble;
    logic            mem_stall;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic            bus_error;
    logic [31:0]     stall_cycles;
    logic [31:0]     flush_events;

    modport master (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               redirect_valid, redirect_pc, dmem_req, dmem_ack,
        output pc_stall, decode_stall, decode_flush, ex_stall, ex_bubble, mem_stall,
               pc_redirect, pc_target, bus_error, stall_cycles, flush_events
    );

    modport slave (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               redirect_valid, redirect_pc, dmem_req, dmem_ack,
        input  pc_stall, decode_stall, decode_flush, ex_stall, ex_bubble, mem_stall,
               pc_redirect, pc_target, bus_error, stall_cycles, flush_events
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared by the synchronous active-low reset.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall / flush / bubble sequencing for the in-order pipeline.
// state    | meaning
// RUN      | normal issue; resolves mem_busy > redirect > load_use
// MEM_WAIT | data memory outstanding; whole pipe frozen until ack or timeout
// FLUSH    | post-redirect squash of decode/EX for the remaining flush cycles
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [8:0]  XLEN         = 9'd64,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [15:0] MEM_TIMEOUT  = 16'd256
) (
    input  logic          clk,
    input  logic          resetn,
    hazard_ctrl_if.master hz
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    ctrl_state_t     r_state, w_state_nxt;
    logic [FCW-1:0]  r_flush_cnt, w_flush_cnt_nxt;
    logic [15:0]     r_wait_cnt, w_wait_cnt_nxt;
    logic            r_bus_error, w_bus_error_nxt;

    logic            w_mem_busy, w_load_use;
    logic            w_pc_stall, w_decode_stall, w_decode_flush;
    logic            w_ex_stall, w_ex_bubble, w_mem_stall;
    logic            w_pc_redirect, w_flush_inc;
    logic [XLEN-1:0] w_pc_target;

    assign w_mem_busy = hz.dmem_req & ~hz.dmem_ack;
    assign w_load_use = hz.id_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                        (src_hit(hz.id_uses_rs1, hz.id_rs1, hz.ex_rd) ||
                         src_hit(hz.id_uses_rs2, hz.id_rs2, hz.ex_rd));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_bus_error <= w_bus_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_bus_error_nxt = r_bus_error;
        w_pc_stall      = 1'b0;
        w_decode_stall  = 1'b0;
        w_decode_flush  = 1'b0;
        w_ex_stall      = 1'b0;
        w_ex_bubble     = 1'b0;
        w_mem_stall     = 1'b0;
        w_pc_redirect   = 1'b0;
        w_flush_inc     = 1'b0;

        if (!resetn) begin
            // keep garbage out of decode/EX while the core is held in reset
            w_decode_flush = 1'b1;
            w_ex_bubble    = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_busy) begin
                        // a coincident redirect stays in frozen EX and is retaken on exit
                        {w_pc_stall, w_decode_stall, w_ex_stall, w_mem_stall} = 4'b1111;
                        w_state_nxt    = MEM_WAIT;
                        w_wait_cnt_nxt = 16'd1;
                    end else if (hz.redirect_valid) begin
                        w_pc_redirect  = 1'b1;
                        w_decode_flush = 1'b1;
                        w_ex_bubble    = 1'b1;
                        w_flush_inc    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt     = FLUSH;
                            w_flush_cnt_nxt = FCW'(FLUSH_CYCLES - 1);
                        end
                    end else if (w_load_use) begin
                        w_pc_stall     = 1'b1;
                        w_decode_stall = 1'b1;
                        w_ex_bubble    = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (hz.dmem_ack) begin
                        w_state_nxt    = RUN;
                        w_wait_cnt_nxt = 16'd0;
                    end else if (r_wait_cnt == (MEM_TIMEOUT - 16'd1)) begin
                        w_bus_error_nxt = 1'b1;
                        w_state_nxt     = RUN;
                        w_wait_cnt_nxt  = 16'd0;
                    end else begin
                        {w_pc_stall, w_decode_stall, w_ex_stall, w_mem_stall} = 4'b1111;
                        w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                    end
                end
                FLUSH: begin
                    w_decode_flush = 1'b1;
                    w_ex_bubble    = 1'b1;
                    if (w_mem_busy) begin
                        {w_pc_stall, w_decode_stall, w_ex_stall, w_mem_stall} = 4'b1111;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
                        if (r_flush_cnt == FCW'(1)) begin
                            w_state_nxt = RUN;
                        end
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    assign w_pc_target = w_pc_redirect ? hz.redirect_pc : '0;

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (w_pc_stall),
        .o_count (hz.stall_cycles)
    );

    sat_counter #(.WIDTH(32)) u_flush_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (w_flush_inc),
        .o_count (hz.flush_events)
    );

    assign hz.pc_stall     = w_pc_stall;
    assign hz.decode_stall = w_decode_stall;
    assign hz.decode_flush = w_decode_flush;
    assign hz.ex_stall     = w_ex_stall;
    assign hz.ex_bubble    = w_ex_bubble;
    assign hz.mem_stall    = w_mem_stall;
    assign hz.pc_redirect  = w_pc_redirect;
    assign hz.pc_target    = w_pc_target;
    assign hz.bus_error    = r_bus_error;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int FC = 2;
    localparam int MT = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    hazard_ctrl_if #(.XLEN(9'd64)) hz();

    hazard_ctrl #(
        .XLEN         (9'd64),
        .FLUSH_CYCLES (FC),
        .MEM_TIMEOUT  (16'(MT))
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (hz)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: remaining memory-wait age (0 = not waiting), remaining extra flush cycles
    int     m_wait    = 0;
    int     m_flush   = 0;
    logic   m_err     = 1'b0;
    longint m_stalls  = 0;
    longint m_flushes = 0;
    bit     m_known   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hz.id_valid       = 1'b0;
        hz.id_rs1         = 5'd0;
        hz.id_rs2         = 5'd0;
        hz.id_uses_rs1    = 1'b0;
        hz.id_uses_rs2    = 1'b0;
        hz.ex_rd          = 5'd0;
        hz.ex_mem_read    = 1'b0;
        hz.redirect_valid = 1'b0;
        hz.redirect_pc    = 64'd0;
        hz.dmem_req       = 1'b0;
        hz.dmem_ack       = 1'b0;
    endtask

    // One clock: check combinational controls and registered status at the negedge,
    // then advance the model across the next posedge.
    task automatic step();
        logic        busy, lu;
        logic        e_pc, e_dec, e_ex, e_mem, e_df, e_eb, e_red, e_inc;
        logic [63:0] e_tgt;
        int          n_wait, n_flush;
        logic        n_err;
        @(negedge clk);
        busy = hz.dmem_req && !hz.dmem_ack;
        lu   = hz.id_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
        {e_pc, e_dec, e_ex, e_mem, e_df, e_eb, e_red, e_inc} = 8'b0;
        e_tgt   = 64'd0;
        n_wait  = m_wait;
        n_flush = m_flush;
        n_err   = m_err;
        if (!resetn) begin
            e_df = 1'b1;
            e_eb = 1'b1;
        end else if (m_wait > 0) begin
            if (hz.dmem_ack) begin
                n_wait = 0;
            end else if (m_wait == MT - 1) begin
                n_err  = 1'b1;
                n_wait = 0;
            end else begin
                {e_pc, e_dec, e_ex, e_mem} = 4'b1111;
                n_wait = m_wait + 1;
            end
        end else if (m_flush > 0) begin
            e_df = 1'b1;
            e_eb = 1'b1;
            if (busy) {e_pc, e_dec, e_ex, e_mem} = 4'b1111;
            else      n_flush = m_flush - 1;
        end else if (busy) begin
            {e_pc, e_dec, e_ex, e_mem} = 4'b1111;
            n_wait = 1;
        end else if (hz.redirect_valid) begin
            e_red   = 1'b1;
            e_tgt   = hz.redirect_pc;
            e_df    = 1'b1;
            e_eb    = 1'b1;
            e_inc   = 1'b1;
            n_flush = FC - 1;
        end else if (lu) begin
            e_pc  = 1'b1;
            e_dec = 1'b1;
            e_eb  = 1'b1;
        end

        check("pc_stall",     hz.pc_stall,     e_pc);
        check("decode_stall", hz.decode_stall, e_dec);
        check("decode_flush", hz.decode_flush, e_df);
        check("ex_stall",     hz.ex_stall,     e_ex);
        check("ex_bubble",    hz.ex_bubble,    e_eb);
        check("mem_stall",    hz.mem_stall,    e_mem);
        check("pc_redirect",  hz.pc_redirect,  e_red);
        check("pc_target",    hz.pc_target,    e_tgt);
        if (m_known) begin
            check("bus_error",    hz.bus_error,    m_err);
            check("stall_cycles", hz.stall_cycles, (m_stalls  > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stalls);
            check("flush_events", hz.flush_events, (m_flushes > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_flushes);
        end

        if (!resetn) begin
            m_wait = 0; m_flush = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
            m_known = 1'b1;
        end else begin
            m_wait    = n_wait;
            m_flush   = n_flush;
            m_err     = n_err;
            m_stalls  = m_stalls + longint'(e_pc);
            m_flushes = m_flushes + longint'(e_inc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        check("rst_bus_error",    hz.bus_error,    0);
        check("rst_stall_cycles", hz.stall_cycles, 0);
        check("rst_flush_events", hz.flush_events, 0);
        step();

        // load-use on rs2, then load leaves EX
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5;
        hz.id_valid = 1'b1; hz.id_uses_rs2 = 1'b1; hz.id_rs2 = 5'd5;
        step();
        hz.ex_mem_read = 1'b0;
        step();
        check("lu_stall_cycles", hz.stall_cycles, 32'd1);
        // x0 destination is never a hazard
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0;
        step();
        check("lu_x0_stall_cycles", hz.stall_cycles, 32'd1);
        idle();

        // redirect with two-cycle flush; second cycle's redirect must be ignored
        hz.redirect_valid = 1'b1; hz.redirect_pc = 64'h8000_0040;
        step();
        check("rd_hold_flush",  hz.decode_flush, 1'b1);
        check("rd_no_redirect", hz.pc_redirect,  1'b0);
        step();
        hz.redirect_valid = 1'b0;
        #1;
        check("rd_back_to_run", hz.decode_flush, 1'b0);
        check("rd_flush_events", hz.flush_events, 32'd1);
        step();

        // memory wait acked on the fourth cycle
        hz.dmem_req = 1'b1;
        repeat (3) step();
        hz.dmem_ack = 1'b1;
        step();
        check("mw_stall_cycles", hz.stall_cycles, 32'd4);
        idle();
        step();

        // timeout: never acked
        hz.dmem_req = 1'b1;
        repeat (4) step();
        check("to_bus_error_set", hz.bus_error, 1'b1);
        check("to_stall_cycles",  hz.stall_cycles, 32'd7);
        idle();
        repeat (3) step();
        check("to_bus_error_sticky", hz.bus_error, 1'b1);

        // simultaneous mem_busy + redirect + load_use
        hz.dmem_req = 1'b1;
        hz.redirect_valid = 1'b1; hz.redirect_pc = 64'h0000_0000_1234_5678;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7;
        hz.id_valid = 1'b1; hz.id_uses_rs1 = 1'b1; hz.id_rs1 = 5'd7;
        step();
        step();
        hz.dmem_ack = 1'b1;
        step();
        hz.dmem_req = 1'b0; hz.dmem_ack = 1'b0;
        #1;
        check("sim_redirect_taken", hz.pc_redirect, 1'b1);
        check("sim_redirect_pc",    hz.pc_target,   64'h0000_0000_1234_5678);
        step();
        idle();
        step();
        step();

        // reset in the middle of a flush
        hz.redirect_valid = 1'b1; hz.redirect_pc = 64'hFFFF_0000_0000_0100;
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        hz.redirect_valid = 1'b0;
        #1;
        check("rf_no_flush_after",  hz.decode_flush, 1'b0);
        check("rf_flush_events",    hz.flush_events, 32'd0);
        check("rf_stall_cycles",    hz.stall_cycles, 32'd0);
        check("rf_bus_error",       hz.bus_error,    1'b0);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            resetn            = ($urandom_range(0, 79) != 0);
            hz.id_valid       = ($urandom_range(0, 3) != 0);
            hz.id_rs1         = 5'($urandom_range(0, 3));
            hz.id_rs2         = 5'($urandom_range(0, 3));
            hz.id_uses_rs1    = 1'($urandom_range(0, 1));
            hz.id_uses_rs2    = 1'($urandom_range(0, 1));
            hz.ex_rd          = 5'($urandom_range(0, 3));
            hz.ex_mem_read    = 1'($urandom_range(0, 1));
            hz.redirect_valid = ($urandom_range(0, 5) == 0);
            hz.redirect_pc    = {32'($urandom), 32'($urandom)};
            hz.dmem_req       = ($urandom_range(0, 3) == 0) || (m_wait > 0 && $urandom_range(0, 1) == 1);
            hz.dmem_ack       = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
